// File: rtl/nios2_ocimem_access_arbiter.sv
// ---------------------------------------------------------------------------
// nios2_ocimem_access_arbiter
//
// Shares the single-port on-chip debug RAM (OCIMEM) between the JTAG
// debug-slave command path and the CPU Avalon debug-mem slave.
// - One-cycle JTAG strobes are latched into a single pending command slot.
// - Requests are arbitrated round-robin while the sequencer is idle.
// - RAM reads and writes are sequenced here, and the results are returned to
//   the JTAG readback (MonDReg / monitor_ready / monitor_error) or to the CPU
//   (avs_readdata / avs_waitrequest).
//
// Configuration macro: OCIMEM_DEBUG_WR_PROTECT_EN
//   defined   : a CPU write with avs_debugaccess=0 completes with normal timing
//               but never raises ram_wren.
//   undefined : every CPU write reaches the RAM.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   jdo[37:0]                  JTAG data: [35] read request, [34] clear error,
//                              [ADDR_W+1:2] word address, [31:0] write data
//   take_action_ocimem_a       load the JTAG address; also read if jdo[35]=1
//   take_no_action_ocimem_a    read at the JTAG address, then increment it
//   take_action_ocimem_b       write jdo[31:0] at the JTAG address, then increment it
//   avs_*                      CPU Avalon slave (read/write held until waitrequest low)
//   ram_addr/wren/byteen/wdata RAM request; ram_rdata returns 1 cycle after ram_addr
//   MonDReg                    data from the last JTAG read
//   monitor_ready              JTAG command complete
//   monitor_error              sticky flag: a JTAG strobe arrived while one was pending
// ---------------------------------------------------------------------------
module nios2_ocimem_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [2:0] {IDLE, J_RD, J_WR, C_RD, C_WR, RD_WAIT} state_t;
  typedef enum logic [1:0] {CMD_LOAD, CMD_READ, CMD_WRITE} jcmd_t;

  state_t              state_reg;
  jcmd_t               jcmd_reg;
  logic                jtag_pend_reg;
  logic [DATA_W-1:0]   jwdata_reg;
  logic [ADDR_W-1:0]   mon_a_reg;
  logic                last_grant_jtag_reg;  // 1: JTAG was served last, 0: CPU

  // Incoming strobe decode.
  logic                strobe_any;
  logic                strobe_accept;
  logic                strobe_drop;
  jcmd_t               in_cmd;
  logic [ADDR_W-1:0]   in_addr;

  // Command actually presented to the arbiter: the pending slot if occupied,
  // otherwise a fresh strobe this cycle.
  jcmd_t               eff_cmd;
  logic [ADDR_W-1:0]   eff_addr;
  logic [DATA_W-1:0]   eff_wdata;

  logic                jtag_req;
  logic                cpu_req;
  logic                grant_jtag;
  logic                grant_cpu;
  logic                cpu_wr_allowed;
  logic [ADDR_W-1:0]   mon_a_inc;

  assign strobe_any    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign strobe_accept = strobe_any & ~jtag_pend_reg;
  assign strobe_drop   = strobe_any & jtag_pend_reg;

  always_comb begin
    in_cmd  = CMD_READ;
    in_addr = mon_a_reg;
    if (take_action_ocimem_a) begin
      in_cmd  = jdo[35] ? CMD_READ : CMD_LOAD;
      in_addr = jdo[ADDR_W+1:2];
    end else if (take_action_ocimem_b) begin
      in_cmd  = CMD_WRITE;
    end
  end

  always_comb begin
    eff_cmd   = in_cmd;
    eff_addr  = in_addr;
    eff_wdata = jdo[DATA_W-1:0];
    if (jtag_pend_reg) begin
      eff_cmd   = jcmd_reg;
      eff_addr  = mon_a_reg;
      eff_wdata = jwdata_reg;
    end
  end

  // A fresh read/write strobe competes in the same cycle it arrives. An
  // address-only load waits one cycle in the slot so that monitor_ready is
  // seen to drop before it rises again.
  assign jtag_req = jtag_pend_reg | (strobe_accept & (in_cmd != CMD_LOAD));

  // waitrequest is low only in the completion cycle; the CPU still holds its
  // request then, so it must not be taken as a new access.
  assign cpu_req    = (avs_read | avs_write) & avs_waitrequest;
  assign grant_jtag = jtag_req & (~cpu_req | ~last_grant_jtag_reg);
  assign grant_cpu  = cpu_req & ~grant_jtag;

`ifdef OCIMEM_DEBUG_WR_PROTECT_EN
  assign cpu_wr_allowed = avs_debugaccess;
`else
  assign cpu_wr_allowed = 1'b1;
  logic unused_debugaccess;
  assign unused_debugaccess = avs_debugaccess;
`endif

  logic unused_jdo_bits;
  assign unused_jdo_bits = ^{jdo[37:36], jdo[33:32]};

  assign mon_a_inc = mon_a_reg + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg           <= IDLE;
      jcmd_reg            <= CMD_LOAD;
      jtag_pend_reg       <= 1'b0;
      jwdata_reg          <= '0;
      mon_a_reg           <= '0;
      last_grant_jtag_reg <= 1'b0;
      avs_readdata        <= '0;
      avs_waitrequest     <= 1'b1;
      ram_addr            <= '0;
      ram_wren            <= 1'b0;
      ram_byteen          <= 4'h0;
      ram_wdata           <= '0;
      MonDReg             <= '0;
      monitor_ready       <= 1'b0;
      monitor_error       <= 1'b0;
    end else begin
      avs_waitrequest <= 1'b1;
      ram_wren        <= 1'b0;

      // Strobe capture runs in every state so JTAG commands queue behind a
      // CPU access. Completion assignments below override these where both
      // apply in the same cycle.
      if (strobe_drop) begin
        monitor_error <= 1'b1;
      end else if (strobe_accept) begin
        jtag_pend_reg <= 1'b1;
        jcmd_reg      <= in_cmd;
        jwdata_reg    <= jdo[DATA_W-1:0];
        monitor_ready <= 1'b0;
        if (take_action_ocimem_a) begin
          mon_a_reg <= in_addr;
          if (jdo[34]) monitor_error <= 1'b0;
        end
      end

      case (state_reg)
        IDLE: begin
          if (grant_jtag) begin
            last_grant_jtag_reg <= 1'b1;
            case (eff_cmd)
              CMD_LOAD: begin
                jtag_pend_reg <= 1'b0;
                monitor_ready <= 1'b1;
              end
              CMD_WRITE: begin
                ram_addr   <= eff_addr;
                ram_wdata  <= eff_wdata;
                ram_byteen <= 4'hF;
                ram_wren   <= 1'b1;
                state_reg  <= J_WR;
              end
              default: begin
                ram_addr  <= eff_addr;
                state_reg <= J_RD;
              end
            endcase
          end else if (grant_cpu) begin
            last_grant_jtag_reg <= 1'b0;
            ram_addr            <= avs_address;
            if (avs_write) begin
              ram_wdata  <= avs_writedata;
              ram_byteen <= avs_byteenable;
              ram_wren   <= cpu_wr_allowed;
              state_reg  <= C_WR;
            end else begin
              state_reg <= C_RD;
            end
          end
        end
        J_RD, C_RD: state_reg <= RD_WAIT;
        J_WR: begin
          state_reg     <= IDLE;
          jtag_pend_reg <= 1'b0;
          monitor_ready <= 1'b1;
          mon_a_reg     <= mon_a_inc;
        end
        C_WR: begin
          state_reg       <= IDLE;
          avs_waitrequest <= 1'b0;
        end
        RD_WAIT: begin
          state_reg <= IDLE;
          // The read owner is whoever was granted last.
          if (last_grant_jtag_reg) begin
            MonDReg       <= ram_rdata;
            jtag_pend_reg <= 1'b0;
            monitor_ready <= 1'b1;
            mon_a_reg     <= mon_a_inc;
          end else begin
            avs_readdata    <= ram_rdata;
            avs_waitrequest <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
